// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
//
// The block sends one byte to the device over the shared open-drain PS/2
// lines. The sequence is: clock inhibit, request-to-send (start bit), 8 data
// bits LSB first, odd parity, stop, and the device ACK. It then reports done
// or error. The receive path on the same pins is not gated by this block.
//
// Ports:
//   CLOCK_50 - system clock, all logic on its rising edge
//   reset    - synchronous, active-low reset
//   data     - command byte, sampled when a send is accepted
//   send     - request, accepted when send && ready
//   ready    - high only while idle
//   done     - one-cycle pulse: frame sent and ACK received
//   error    - one-cycle pulse: frame aborted
//   err_code - 01 start timeout, 10 transfer timeout, 11 no ACK;
//              held until the next accept
//   PS2_CLK  - open-drain clock line, driven 0 or Z
//   PS2_DAT  - open-drain data line, driven 0 or Z
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned XFER_TIMEOUT   = 100000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ready,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    localparam int unsigned CMAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int unsigned CMAX   = (CMAX_A > XFER_TIMEOUT) ? CMAX_A : XFER_TIMEOUT;
    localparam int unsigned CW     = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_FAIL
    } state_t;

    state_t                 state_q;
    logic                   clk_oe_q;
    logic                   dat_oe_q;
    logic                   ready_q;
    logic                   done_q;
    logic                   error_q;
    logic [1:0]             err_code_q;
    logic [CW-1:0]          cnt_q;
    logic [3:0]             n_q;
    logic [8:0]             frame_q;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    // Open-drain drivers: a 1 bit is represented by releasing the line.
    assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;

    assign ready    = ready_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall  = clk_prev_q & ~clk_s;

    // Synchronizers reset to the idle (released) level so that leaving reset
    // never produces a spurious falling edge.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q[0] <= PS2_CLK;
            dat_sync_q[0] <= PS2_DAT;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                clk_sync_q[i] <= clk_sync_q[i-1];
                dat_sync_q[i] <= dat_sync_q[i-1];
            end
            clk_prev_q <= clk_s;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
            cnt_q      <= '0;
            n_q        <= '0;
            frame_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (send && ready_q) begin
                        frame_q    <= {~^data, data};
                        err_code_q <= '0;
                        cnt_q      <= '0;
                        n_q        <= '0;
                        clk_oe_q   <= 1'b1;
                        dat_oe_q   <= 1'b0;
                        ready_q    <= 1'b0;
                        state_q    <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (32'(cnt_q) + 32'd1 >= INHIBIT_CYCLES) begin
                        // Start bit and clock release on the same edge.
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_REQ;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_REQ: begin
                    if (32'(cnt_q) >= START_TIMEOUT) begin
                        err_code_q <= 2'b01;
                        clk_oe_q   <= 1'b0;
                        dat_oe_q   <= 1'b0;
                        state_q    <= S_FAIL;
                    end else if (fall) begin
                        dat_oe_q <= ~frame_q[0];
                        frame_q  <= {1'b0, frame_q[8:1]};
                        n_q      <= 4'd1;
                        cnt_q    <= '0;
                        state_q  <= S_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_SHIFT, S_ACK: begin
                    // One timer spans SHIFT and ACK; timeout beats a
                    // coincident falling edge.
                    if (32'(cnt_q) >= XFER_TIMEOUT) begin
                        err_code_q <= 2'b10;
                        clk_oe_q   <= 1'b0;
                        dat_oe_q   <= 1'b0;
                        state_q    <= S_FAIL;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (fall) begin
                            if (state_q == S_SHIFT) begin
                                n_q <= n_q + 4'd1;
                                if (n_q + 4'd1 <= 4'd9) begin
                                    dat_oe_q <= ~frame_q[0];
                                    frame_q  <= {1'b0, frame_q[8:1]};
                                end else begin
                                    dat_oe_q <= 1'b0;
                                    state_q  <= S_ACK;
                                end
                            end else if (!dat_s) begin
                                state_q <= S_WAIT_IDLE;
                            end else begin
                                err_code_q <= 2'b11;
                                clk_oe_q   <= 1'b0;
                                dat_oe_q   <= 1'b0;
                                state_q    <= S_FAIL;
                            end
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    if (clk_s && dat_s) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                S_FAIL: begin
                    error_q  <= 1'b1;
                    ready_q  <= 1'b1;
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    state_q  <= S_IDLE;
                end

                default: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    ready_q  <= 1'b1;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int unsigned INH  = 50;
    localparam int unsigned ST   = 600;
    localparam int unsigned XT   = 1500;
    localparam int unsigned SS   = 2;
    localparam int          HALF = 20;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       send  = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    wire        ps2_clk;
    wire        ps2_dat;

    logic bfm_clk_low = 1'b0;
    logic bfm_dat_low = 1'b0;
    assign ps2_clk = bfm_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = bfm_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int err_cyc = 0;
    int first_fall_cyc = 0;
    logic [1:0] last_code = 2'b00;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (ST),
        .XFER_TIMEOUT  (XT),
        .SYNC_STAGES   (SS)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst_n),
        .data    (data),
        .send    (send),
        .ready   (ready),
        .done    (done),
        .error   (error),
        .err_code(err_code),
        .PS2_CLK (ps2_clk),
        .PS2_DAT (ps2_dat)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) begin
            err_cnt++;
            err_cyc   = cyc;
            last_code = err_code;
        end
        if (done === 1'b1 && error === 1'b1) both_cnt++;
    end

    // Reference frame as the device sees it: bit0 start, bits1..8 data LSB
    // first, bit9 odd parity, bit10 stop.
    function automatic logic [10:0] expected_frame(input logic [7:0] d);
        int ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) ones += (int'(d) >> i) & 1;
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic do_send(input logic [7:0] d, output int acc);
        @(negedge clk);
        data = d;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        acc  = cyc;
    endtask

    // Device model: waits for request-to-send, then generates 'edges' clock
    // pulses, sampling the host data at the end of each low phase.
    task automatic device_frame(input int edges, input bit give_ack,
                                output logic [10:0] got);
        int w = 0;
        got = '1;
        while (!(ps2_clk === 1'b1 && ps2_dat === 1'b0) && w < INH + 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= INH + 200) return;
        repeat (HALF) @(negedge clk);
        got[0] = ps2_dat;
        for (int k = 1; k <= edges && k <= 11; k++) begin
            if (k == 11 && give_ack) begin
                bfm_dat_low = 1'b1;
                repeat (HALF / 2) @(negedge clk);
            end
            if (k == 1) first_fall_cyc = cyc;
            bfm_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (k <= 10) got[k] = ps2_dat;
            bfm_clk_low = 1'b0;
            if (k == 11) bfm_dat_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (ready !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: ready=%b done=%b error=%b, want 1 0 0", ready, done, error);
        end
        tests++;
        if (err_code !== 2'b00) begin
            fails++;
            $display("FAIL reset_err_code: got %b want 00", err_code);
        end
        tests++;
        if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1) begin
            fails++;
            $display("FAIL reset_lines: clk=%b dat=%b want 1 1", ps2_clk, ps2_dat);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_frame(input logic [7:0] d);
        int acc;
        int lo = 0;
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [10:0] got;
        logic [10:0] exp = expected_frame(d);
        do_send(d, acc);
        fork
            begin
                while (ps2_clk === 1'b0 && lo < int'(INH) + 100) begin
                    lo++;
                    @(negedge clk);
                end
            end
            device_frame(11, 1'b1, got);
        join
        for (int w = 0; w < 200 && done_cnt == d0; w++) @(negedge clk);
        repeat (3) @(negedge clk);
        tests++;
        if (lo != int'(INH)) begin
            fails++;
            $display("FAIL inhibit_len[%h]: clk low %0d cycles, want %0d", d, lo, INH);
        end
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL frame_bits[%h]: got %b want %b", d, got, exp);
        end
        tests++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            fails++;
            $display("FAIL frame_pulses[%h]: done %0d error %0d, want 1 0", d, done_cnt - d0, err_cnt - e0);
        end
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL frame_ready[%h]: got %b want 1", d, ready);
        end
    endtask

    task automatic test_random_frames;
        for (int i = 0; i < 5; i++) test_frame(8'($urandom));
    endtask

    task automatic test_no_device;
        int acc;
        int d0 = done_cnt;
        int e0 = err_cnt;
        int dt;
        do_send(8'hED, acc);
        for (int w = 0; w < int'(INH + ST) + 200 && err_cnt == e0; w++) @(negedge clk);
        repeat (3) @(negedge clk);
        dt = err_cyc - acc - int'(INH + ST);
        tests++;
        if (err_cnt - e0 != 1 || last_code !== 2'b01 || done_cnt != d0) begin
            fails++;
            $display("FAIL start_timeout: errors %0d code %b done %0d, want 1 01 0", err_cnt - e0, last_code, done_cnt - d0);
        end
        tests++;
        if (dt < -int'(SS + 2) || dt > int'(SS + 2)) begin
            fails++;
            $display("FAIL start_timeout_time: offset %0d cycles, want within +-%0d", dt, SS + 2);
        end
        tests++;
        if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1 || ready !== 1'b1) begin
            fails++;
            $display("FAIL start_timeout_release: clk=%b dat=%b ready=%b want 1 1 1", ps2_clk, ps2_dat, ready);
        end
    endtask

    task automatic test_no_ack;
        int acc;
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [10:0] got;
        do_send(8'($urandom), acc);
        device_frame(11, 1'b0, got);
        for (int w = 0; w < 200 && err_cnt == e0; w++) @(negedge clk);
        repeat (3) @(negedge clk);
        tests++;
        if (err_cnt - e0 != 1 || last_code !== 2'b11 || done_cnt != d0) begin
            fails++;
            $display("FAIL no_ack: errors %0d code %b done %0d, want 1 11 0", err_cnt - e0, last_code, done_cnt - d0);
        end
    endtask

    task automatic test_xfer_timeout;
        int acc;
        int d0 = done_cnt;
        int e0 = err_cnt;
        int dt;
        logic [10:0] got;
        do_send(8'($urandom), acc);
        device_frame(4, 1'b1, got);
        for (int w = 0; w < int'(XT) + 200 && err_cnt == e0; w++) @(negedge clk);
        repeat (3) @(negedge clk);
        dt = err_cyc - first_fall_cyc;
        tests++;
        if (err_cnt - e0 != 1 || last_code !== 2'b10 || done_cnt != d0) begin
            fails++;
            $display("FAIL xfer_timeout: errors %0d code %b done %0d, want 1 10 0", err_cnt - e0, last_code, done_cnt - d0);
        end
        tests++;
        if (dt < int'(XT) || dt > int'(XT + SS) + 6) begin
            fails++;
            $display("FAIL xfer_timeout_time: %0d cycles after first fall, want %0d..%0d", dt, XT, XT + SS + 6);
        end
        tests++;
        if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1) begin
            fails++;
            $display("FAIL xfer_timeout_release: clk=%b dat=%b want 1 1", ps2_clk, ps2_dat);
        end
    endtask

    task automatic test_send_ignored;
        int acc;
        int d0 = done_cnt;
        int lows = 0;
        logic [7:0]  d = 8'($urandom);
        logic [10:0] got;
        logic [10:0] exp = expected_frame(d);
        do_send(d, acc);
        fork
            device_frame(11, 1'b1, got);
            begin
                repeat (int'(INH) + 10 * HALF) @(negedge clk);
                data = ~d;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        for (int w = 0; w < 200 && done_cnt == d0; w++) @(negedge clk);
        for (int w = 0; w < 30; w++) begin
            if (ps2_clk === 1'b0) lows++;
            @(negedge clk);
        end
        tests++;
        if (got !== exp || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL send_ignored_frame: got %b done %0d, want %b 1", got, done_cnt - d0, exp);
        end
        tests++;
        if (lows != 0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL send_ignored_queue: clk low %0d cycles ready=%b, want 0 1", lows, ready);
        end
    endtask

    task automatic test_reset_midframe;
        int acc;
        int d0;
        int e0;
        logic [10:0] got;
        do_send(8'($urandom), acc);
        device_frame(5, 1'b1, got);
        d0 = done_cnt;
        e0 = err_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1 || ready !== 1'b1) begin
            fails++;
            $display("FAIL midframe_reset: clk=%b dat=%b ready=%b want 1 1 1", ps2_clk, ps2_dat, ready);
        end
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        tests++;
        if (done_cnt != d0 || err_cnt != e0) begin
            fails++;
            $display("FAIL midframe_pulses: done %0d error %0d, want 0 0", done_cnt - d0, err_cnt - e0);
        end
        test_frame(8'hF4);
    endtask

    task automatic test_exclusive;
        tests++;
        if (both_cnt != 0) begin
            fails++;
            $display("FAIL done_error_overlap: %0d cycles, want 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hED);
        test_frame(8'h07);
        test_frame(8'h00);
        test_random_frames();
        test_no_device();
        test_no_ack();
        test_xfer_timeout();
        test_send_ignored();
        test_reset_midframe();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
